router_in_port: RTL

//  Per-port input stage of the 8x8 router. Parses one serial ingress lane (frame_n/valid_n/di).

---
 rtl/router_pkg.sv | 16 +
 rtl/router_in_port_if.sv | 16 +
 rtl/router_pkt_fifo.sv | 42 ++++
 rtl/router_in_port.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the 8x8 router: packet word, input-parser states, saturating counter helper.
package router_pkg;
  localparam int DA_W = 4;
  localparam int PL_W = 32;

  typedef struct packed {
    logic [DA_W-1:0] da;
    logic [PL_W-1:0] data;
  } pkt_t;

  typedef enum logic [2:0] {SYNC, IDLE, ADDR, PAD, PAY, DRAIN, DONE} in_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/router_in_port_if.sv
// Ingress serial lane plus parallel packet output handshake of one router input port.
interface router_in_port_if;
  import router_pkg::*;
  logic            frame_n;
  logic            valid_n;
  logic            di;
  logic            out_valid;
  logic            out_ready;
  logic [DA_W-1:0] out_da;
  logic [PL_W-1:0] out_data;

  modport master (output frame_n, valid_n, di, out_ready,
                  input  out_valid, out_da, out_data);
  modport slave  (input  frame_n, valid_n, di, out_ready,
                  output out_valid, out_da, out_data);
endinterface

// File: rtl/router_pkt_fifo.sv
// Show-ahead packet FIFO; head reads as zero when empty, push+pop on full keeps count.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push_i,
  input  logic pop_i,
  input  pkt_t din_i,
  output pkt_t dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  pkt_t          mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot the push needs; empty never bypasses
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/router_in_port.sv
// Router input port: serial frame parser feeding a packet FIFO.
// Define ROUTER_IN_STATS_EN to build the saturating err_cnt/drop_cnt counters.
module router_in_port
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_PAD = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  router_in_port_if.slave  lane,
  output logic             busy,
  output logic [7:0]       err_cnt,
  output logic [7:0]       drop_cnt
);
  localparam logic [2:0] ST_SYNC  = 3'(SYNC);
  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_ADDR  = 3'(ADDR);
  localparam logic [2:0] ST_PAD   = 3'(PAD);
  localparam logic [2:0] ST_PAY   = 3'(PAY);
  localparam logic [2:0] ST_DRAIN = 3'(DRAIN);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

  localparam int BW  = $clog2(PL_W);
  localparam int DAB = $clog2(DA_W);
  localparam int PW  = $clog2(MAX_PAD + 2);

  logic [2:0]      state_q, state_d;
  logic [DA_W-1:0] da_q, da_d;
  logic [PL_W-1:0] data_q, data_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PW-1:0]   pad_q, pad_d;
  logic            err, push, drop, pop;
  logic            fifo_full, fifo_empty;
  pkt_t            pkt_in, head;

  always_comb begin
    state_d = state_q;
    da_d    = da_q;
    data_d  = data_q;
    bit_d   = bit_q;
    pad_d   = pad_q;
    err     = 1'b0;
    case (state_q)
      ST_SYNC: if (lane.frame_n) state_d = ST_IDLE;
      // DONE also starts the next frame so packets may run back-to-back
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (!lane.frame_n) begin
          da_d    = {{(DA_W-1){1'b0}}, lane.di};
          bit_d   = BW'(1);
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (lane.frame_n) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          da_d[bit_q[DAB-1:0]] = lane.di;
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(DA_W-1)) begin
            bit_d   = '0;
            pad_d   = '0;
            state_d = ST_PAD;
          end
        end
      end
      // first qualified bit in PAD is payload bit 0, handled exactly like PAY
      ST_PAD, ST_PAY: begin
        if (!lane.valid_n) begin
          data_d[bit_q] = lane.di;
          bit_d   = bit_q + BW'(1);
          state_d = ST_PAY;
          if (bit_q == BW'(PL_W-1)) begin
            state_d = lane.frame_n ? ST_DONE : ST_DRAIN;
            err     = !lane.frame_n;
          end else if (lane.frame_n) begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (lane.frame_n) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_PAD) begin
          if (pad_q == PW'(MAX_PAD)) begin
            err     = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            pad_d = pad_q + PW'(1);
          end
        end
      end
      ST_DRAIN: if (lane.frame_n) state_d = ST_IDLE;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_SYNC;
      da_q    <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      da_q    <= da_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      pad_q   <= pad_d;
    end
  end

  assign busy   = (state_q != ST_SYNC) && (state_q != ST_IDLE);
  assign push   = (state_q == ST_DONE);
  assign pop    = !fifo_empty && lane.out_ready;
  assign drop   = push && fifo_full && !pop;
  assign pkt_in = '{da: da_q, data: data_q};

  router_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pkt_in),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign lane.out_valid = !fifo_empty;
  assign lane.out_da    = head.da;
  assign lane.out_data  = head.data;

`ifdef ROUTER_IN_STATS_EN
  logic [7:0] err_cnt_q, drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (err)  err_cnt_q  <= sat_inc(err_cnt_q);
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = err | drop;
  assign err_cnt  = '0;
  assign drop_cnt = '0;
`endif
endmodule
